// File: rtl/im_addr_sequencer.sv
// Multi-channel strided item-memory address generator.
// Each channel runs an independent IDLE/RUN sequencer with a valid/ready address port.
module im_addr_sequencer #(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned NumTotIm     = 1024,
  parameter int unsigned NumCh        = 2,
  parameter int unsigned ImAddrWidth  = $clog2(NumTotIm)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    en_i,
  input  logic [NumCh-1:0]                        clr_i,
  input  logic [NumCh-1:0]                        start_i,
  input  logic [NumCh-1:0]                        mode_i,
  input  logic [NumCh-1:0][CsrDataWidth-1:0]      start_count_i,
  input  logic [NumCh-1:0][CsrDataWidth-1:0]      stride_i,
  input  logic [NumCh-1:0][CsrDataWidth-1:0]      max_count_i,
  input  logic [NumCh-1:0][CsrDataWidth-1:0]      repeat_i,
  output logic [NumCh-1:0][ImAddrWidth-1:0]       addr_o,
  output logic [NumCh-1:0]                        addr_valid_o,
  input  logic [NumCh-1:0]                        addr_ready_i,
  output logic [NumCh-1:0]                        last_o,
  output logic [NumCh-1:0]                        done_o,
  output logic                                    busy_o
);

  // state   | meaning
  // ST_IDLE | no sequence active, outputs quiet
  // ST_RUN  | presenting r_addr, advancing on each handshake
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                  r_state  [NumCh];
  logic [ImAddrWidth-1:0]  r_addr   [NumCh];
  logic [ImAddrWidth-1:0]  r_start  [NumCh];
  logic [ImAddrWidth-1:0]  r_stride [NumCh];
  logic [CsrDataWidth-1:0] r_idx    [NumCh];
  logic [CsrDataWidth-1:0] r_len    [NumCh];
  logic [CsrDataWidth-1:0] r_pass   [NumCh];
  logic [CsrDataWidth-1:0] r_rep    [NumCh];
  logic [NumCh-1:0]        r_mode;
  logic [NumCh-1:0]        r_done;

  logic [NumCh-1:0]        w_run;
  logic [NumCh-1:0]        w_hs;
  logic [NumCh-1:0]        w_end;
  logic                    w_unused_cfg;

  always_comb begin
    w_run        = '0;
    w_hs         = '0;
    w_end        = '0;
    w_unused_cfg = 1'b0;
    for (int c = 0; c < NumCh; c++) begin
      w_run[c]     = (r_state[c] == ST_RUN);
      w_hs[c]      = w_run[c] & addr_ready_i[c];
      w_end[c]     = (r_idx[c] == r_len[c] - CsrDataWidth'(1));
      w_unused_cfg = w_unused_cfg ^ (^start_count_i[c][CsrDataWidth-1:ImAddrWidth])
                                  ^ (^stride_i[c][CsrDataWidth-1:ImAddrWidth]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode <= '0;
      r_done <= '0;
      for (int c = 0; c < NumCh; c++) begin
        r_state[c]  <= ST_IDLE;
        r_addr[c]   <= '0;
        r_start[c]  <= '0;
        r_stride[c] <= '0;
        r_idx[c]    <= '0;
        r_len[c]    <= '0;
        r_pass[c]   <= '0;
        r_rep[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        r_done[c] <= 1'b0;
        if (!en_i) begin
          r_state[c]  <= ST_IDLE;
          r_addr[c]   <= '0;
          r_start[c]  <= '0;
          r_stride[c] <= '0;
          r_idx[c]    <= '0;
          r_len[c]    <= '0;
          r_pass[c]   <= '0;
          r_rep[c]    <= '0;
          r_mode[c]   <= 1'b0;
        end else if (clr_i[c]) begin
          r_state[c] <= ST_IDLE;
        end else if (start_i[c]) begin
          // zero length / repeat count behave as one
          r_state[c]  <= ST_RUN;
          r_start[c]  <= start_count_i[c][ImAddrWidth-1:0];
          r_stride[c] <= stride_i[c][ImAddrWidth-1:0];
          r_len[c]    <= (max_count_i[c] == '0) ? CsrDataWidth'(1) : max_count_i[c];
          r_rep[c]    <= (repeat_i[c] == '0) ? CsrDataWidth'(1) : repeat_i[c];
          r_mode[c]   <= mode_i[c];
          r_addr[c]   <= start_count_i[c][ImAddrWidth-1:0];
          r_idx[c]    <= '0;
          r_pass[c]   <= '0;
        end else if (w_hs[c]) begin
          if (!w_end[c]) begin
            r_idx[c]  <= r_idx[c] + CsrDataWidth'(1);
            r_addr[c] <= r_addr[c] + r_stride[c];
          end else if (r_mode[c]) begin
            r_idx[c]  <= '0;
            r_addr[c] <= r_start[c];
          end else if (r_pass[c] != r_rep[c] - CsrDataWidth'(1)) begin
            r_idx[c]  <= '0;
            r_addr[c] <= r_start[c];
            r_pass[c] <= r_pass[c] + CsrDataWidth'(1);
          end else begin
            r_state[c] <= ST_IDLE;
            r_done[c]  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    addr_o       = '0;
    addr_valid_o = '0;
    last_o       = '0;
    for (int c = 0; c < NumCh; c++) begin
      addr_o[c]       = w_run[c] ? r_addr[c] : '0;
      addr_valid_o[c] = w_run[c];
      last_o[c]       = w_run[c] & w_end[c];
    end
  end

  assign done_o = r_done;
  assign busy_o = |w_run;

endmodule
